program_runner: RTL and testbench
=================================

// Module: program_runner
// PURPOSE
//  Executes the 26-bit wash program word produced by the settings model (sourceData).
//  Latches the word on start, then steps through up to eight timed phases: wash fill,
//  wash, drain, spin, rinse fill, rinse, drain, spin.
//  Counts each phase down on time-unit ticks and drives valve and motor enables.
//  Sits between the settings model and the actuator and display logic.
// PARAMETERS
//  UNIT_TICKS  1  tick pulses per program time unit (>=1); internal prescaler width $clog2(UNIT_TICKS+1)
// PORTS
//  cp          in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  prog        in   26  program word, sampled only on accepted start
//  start       in   1   1-cycle pulse; begin program
//  pause       in   1   level; freeze execution while high
//  abort       in   1   1-cycle pulse; cancel and return to IDLE
//  tick        in   1   1-cycle time base pulse
//  phase       out  3   current phase index 0..7 (0 when idle)
//  remain      out  4   time units left in current phase
//  water_in    out  1   fill valve (phases 0,4)
//  drain       out  1   drain valve (phases 2,3,6,7)
//  motor_wash  out  1   wash motor (phases 1,5)
//  motor_spin  out  1   spin motor (phases 3,7)
//  busy        out  1   high in RUN or PAUSE
//  done        out  1   1-cycle pulse on program completion
// BEHAVIOUR
//  Field map, MSB first: [25:23] ph0, [22:19] ph1, [18:16] ph2, [15:13] ph3,
//  [12:10] ph4, [9:6] ph5, [5:3] ph6, [2:0] ph7. Fields zero-extend to 4 bits.
//  Reset: state IDLE; prog_q, phase, remain, prescaler = 0; all outputs 0.
//  States: IDLE, RUN, PAUSE, FINISH.
//  IDLE + start:
//   - Latch prog into prog_q.
//   - If any field is nonzero, go to RUN at the next edge. Load phase with the lowest
//     nonzero index and remain with that field.
//   - If prog == 0, go to FINISH.
//  RUN:
//   - The prescaler counts ticks. Each UNIT_TICKS-th tick is one unit; the prescaler then clears.
//   - On a unit with remain > 1: remain decrements.
//   - On a unit with remain == 1: in the same edge, load the next nonzero phase above the
//     current one (zero fields are skipped; no cycle is spent on them). If none remains,
//     go to FINISH with remain = 0.
//  RUN + pause high: go to PAUSE. A tick in that same cycle is dropped.
//  PAUSE:
//   - phase, remain and prescaler hold. All actuator outputs are 0.
//   - pause low: return to RUN at the next edge.
//  FINISH: lasts 1 cycle with done = 1. Then IDLE with phase = 0.
//  Actuator outputs:
//   - Registered decode of phase, valid only in RUN.
//   - Forced to 0 in IDLE, PAUSE and FINISH.
//  Priority:
//   - abort beats start, pause and tick; abort in any state gives IDLE and clears all
//     registers at the next edge.
//   - start is ignored outside IDLE; re-latching mid-run is not allowed.
//   - pause in IDLE is ignored. A start held with pause high enters RUN, then PAUSE.
//  Reset mid-operation: immediate asynchronous return to reset values. No done pulse.
// CONFIGURATION
//  LID_LOCK_EN defined:
//   - Adds input lid_open (1) and output err (1).
//   - lid_open high in RUN or PAUSE: go to PAUSE with err = 1 (sticky). err clears only
//     on abort or reset.
//   - While err = 1, a falling pause does not resume. start is ignored while err = 1.
//  LID_LOCK_EN undefined: lid_open and err ports do not exist; no lid checking.
// TESTING
//  T1 UNIT_TICKS=1, prog=26'b011_1010_100_101_011_1000_100_101, start, then 42 ticks
//     -> phase 0..7 in order, with remain loads 3,10,4,5,3,8,4,5.
//     -> done pulses 1 cycle after the 42nd tick's edge; busy then falls.
//  T2 prog=26'b000_0000_000_000_000_0000_100_101, start
//     -> phase = 6, remain = 4, drain = 1.
//     -> after 9 ticks: done; phases 0..5 never appear.
//  T3 prog=0, start -> busy never high; done high the 2nd cycle after start.
//  T4 wash-only program, pause high at phase 1 with remain = 7, 5 ticks during pause
//     -> remain stays 7 and motor_wash = 0.
//     -> after release, 7 more ticks reach done.
//  T5 abort and start in the same cycle during phase 5
//     -> IDLE at the next edge, all outputs 0, no done, prog not re-latched.
//  T6 (LID_LOCK_EN) lid_open pulse in RUN
//     -> err = 1, PAUSE; pause toggling has no effect.
//     -> abort clears err; the next start runs normally.

Source files
------------

// File: rtl/program_runner_if.sv
// Bus between the settings model, program_runner and the actuator/display logic.
// LID_LOCK_EN adds the lid_open input and sticky err output.
interface program_runner_if;
    logic [25:0] prog;
    logic        start;
    logic        pause;
    logic        abort;
    logic        tick;
    logic [2:0]  phase;
    logic [3:0]  remain;
    logic        water_in;
    logic        drain;
    logic        motor_wash;
    logic        motor_spin;
    logic        busy;
    logic        done;
`ifdef LID_LOCK_EN
    logic        lid_open;
    logic        err;

    modport master (
        output prog, start, pause, abort, tick, lid_open,
        input  phase, remain, water_in, drain, motor_wash, motor_spin, busy, done, err
    );
    modport slave (
        input  prog, start, pause, abort, tick, lid_open,
        output phase, remain, water_in, drain, motor_wash, motor_spin, busy, done, err
    );
`else
    modport master (
        output prog, start, pause, abort, tick,
        input  phase, remain, water_in, drain, motor_wash, motor_spin, busy, done
    );
    modport slave (
        input  prog, start, pause, abort, tick,
        output phase, remain, water_in, drain, motor_wash, motor_spin, busy, done
    );
`endif
endinterface

// File: rtl/program_runner.sv
// Wash program sequencer: latches a 26-bit program word and steps through eight timed phases.
// Optional lid interlock enabled by defining LID_LOCK_EN.
module program_runner #(
    parameter int unsigned UNIT_TICKS = 1
) (
    input logic             cp,
    input logic             rst_n,
    program_runner_if.slave bus
);

    localparam int unsigned PW = $clog2(UNIT_TICKS + 1);
    localparam logic [PW-1:0] PrescLast = PW'(UNIT_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StFinish} state_e;

    state_e        state_q, state_d;
    logic [25:0]   prog_q, prog_d;
    logic [2:0]    phase_q, phase_d;
    logic [3:0]    remain_q, remain_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    act_q, act_d;  // {water_in, drain, motor_wash, motor_spin}
    logic          err_q, err_d;
    logic          lid_hit;
    logic [3:0]    start_nxt, run_nxt;

    function automatic logic [3:0] field(input logic [25:0] p, input logic [2:0] idx);
        logic [3:0] res;
        case (idx)
            3'd0:    res = {1'b0, p[25:23]};
            3'd1:    res = p[22:19];
            3'd2:    res = {1'b0, p[18:16]};
            3'd3:    res = {1'b0, p[15:13]};
            3'd4:    res = {1'b0, p[12:10]};
            3'd5:    res = p[9:6];
            3'd6:    res = {1'b0, p[5:3]};
            default: res = {1'b0, p[2:0]};
        endcase
        return res;
    endfunction

    // Returns {found, index} of the lowest nonzero field at or above 'from'.
    function automatic logic [3:0] next_phase(input logic [25:0] p, input logic [3:0] from);
        logic       found;
        logic [2:0] idx;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (4'(i) >= from && field(p, 3'(i)) != 4'd0) begin
                found = 1'b1;
                idx   = 3'(i);
            end
        end
        return {found, idx};
    endfunction

    assign start_nxt = next_phase(bus.prog, 4'd0);
    assign run_nxt   = next_phase(prog_q, {1'b0, phase_q} + 4'd1);

`ifdef LID_LOCK_EN
    assign lid_hit = bus.lid_open;
    assign bus.err = err_q;
`else
    assign lid_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        prog_d   = prog_q;
        phase_d  = phase_q;
        remain_d = remain_q;
        presc_d  = presc_q;
        err_d    = err_q;
        act_d    = 4'd0;
        if (bus.abort) begin
            state_d  = StIdle;
            prog_d   = '0;
            phase_d  = '0;
            remain_d = '0;
            presc_d  = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start && !err_q) begin
                        prog_d = bus.prog;
                        if (start_nxt[3]) begin
                            state_d  = StRun;
                            phase_d  = start_nxt[2:0];
                            remain_d = field(bus.prog, start_nxt[2:0]);
                            presc_d  = '0;
                        end else begin
                            state_d = StFinish;
                        end
                    end
                end
                StRun: begin
                    if (lid_hit) begin
                        state_d = StPause;
                        err_d   = 1'b1;
                    end else if (bus.pause) begin
                        state_d = StPause;
                    end else if (bus.tick) begin
                        if (presc_q == PrescLast) begin
                            presc_d = '0;
                            if (remain_q > 4'd1) begin
                                remain_d = remain_q - 4'd1;
                            end else if (run_nxt[3]) begin
                                phase_d  = run_nxt[2:0];
                                remain_d = field(prog_q, run_nxt[2:0]);
                            end else begin
                                state_d  = StFinish;
                                remain_d = '0;
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                StPause: begin
                    if (lid_hit) begin
                        err_d = 1'b1;
                    end else if (!bus.pause && !err_q) begin
                        state_d = StRun;
                    end
                end
                StFinish: begin
                    state_d  = StIdle;
                    phase_d  = '0;
                    remain_d = '0;
                    presc_d  = '0;
                end
                default: state_d = StIdle;
            endcase
        end
        // Actuators are registered so they line up with the phase they decode.
        if (state_d == StRun) begin
            act_d = {phase_d[1:0] == 2'd0, phase_d[1], phase_d[1:0] == 2'd1,
                     phase_d[1:0] == 2'd3};
        end
    end

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            prog_q   <= '0;
            phase_q  <= '0;
            remain_q <= '0;
            presc_q  <= '0;
            act_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prog_q   <= prog_d;
            phase_q  <= phase_d;
            remain_q <= remain_d;
            presc_q  <= presc_d;
            act_q    <= act_d;
            err_q    <= err_d;
        end
    end

    assign bus.phase      = phase_q;
    assign bus.remain     = remain_q;
    assign bus.water_in   = act_q[3];
    assign bus.drain      = act_q[2];
    assign bus.motor_wash = act_q[1];
    assign bus.motor_spin = act_q[0];
    assign bus.busy       = (state_q == StRun) || (state_q == StPause);
    assign bus.done       = (state_q == StFinish);

endmodule

// File: tb/tb_program_runner.sv
// Directed bench for program_runner: vector table of whole programs plus hand-written
// sequences for pause, abort, zero program, reset and (with LID_LOCK_EN) the lid interlock.
module tb_program_runner;

    logic cp;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    program_runner_if bus ();

    program_runner #(.UNIT_TICKS(1)) dut (
        .cp    (cp),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish, got hung, required finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [25:0] prog;
        logic [2:0]  ph;
        logic [3:0]  rem;
        logic [3:0]  act;
        int          units;
    } vec_t;

    localparam logic [25:0] ProgT1 = 26'b011_1010_100_101_011_1000_100_101;

    task automatic cyc();
        @(posedge cp);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] acts_now();
        return {bus.water_in, bus.drain, bus.motor_wash, bus.motor_spin};
    endfunction

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            cyc();
        end
        bus.tick = 1'b0;
    endtask

    task automatic do_start(input logic [25:0] p);
        bus.prog  = p;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    vec_t vecs[7];
    int   loads[8] = '{3, 10, 4, 5, 3, 8, 4, 5};
    logic [3:0] pacts[8] = '{4'b1000, 4'b0010, 4'b0100, 4'b0101,
                             4'b1000, 4'b0010, 4'b0100, 4'b0101};

    initial begin
        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{ProgT1, 3'd0, 4'd3, 4'b1000, 42};
        vecs[1] = '{26'b000_0000_000_000_000_0000_100_101, 3'd6, 4'd4, 4'b0100, 9};
        vecs[2] = '{26'd7 << 19, 3'd1, 4'd7, 4'b0010, 7};
        vecs[3] = '{26'd1, 3'd7, 4'd1, 4'b0101, 1};
        vecs[4] = '{26'd7 << 13, 3'd3, 4'd7, 4'b0101, 7};
        vecs[5] = '{26'd15 << 6, 3'd5, 4'd15, 4'b0010, 15};
        vecs[6] = '{(26'd1 << 23) | (26'd2 << 10), 3'd0, 4'd1, 4'b1000, 3};

        rst_n     = 1'b0;
        bus.prog  = '0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.abort = 1'b0;
        bus.tick  = 1'b0;
`ifdef LID_LOCK_EN
        bus.lid_open = 1'b0;
`endif
        cyc();
        cyc();
        chk("rst_phase", 32'(bus.phase), 0);
        chk("rst_remain", 32'(bus.remain), 0);
        chk("rst_act", 32'(acts_now()), 0);
        chk("rst_busy_done", 32'({bus.busy, bus.done}), 0);
        rst_n = 1'b1;
        cyc();

        // Whole programs from the table.
        for (int v = 0; v < 7; v++) begin
            do_start(vecs[v].prog);
            chk($sformatf("v%0d_phase", v), 32'(bus.phase), 32'(vecs[v].ph));
            chk($sformatf("v%0d_remain", v), 32'(bus.remain), 32'(vecs[v].rem));
            chk($sformatf("v%0d_act", v), 32'(acts_now()), 32'(vecs[v].act));
            chk($sformatf("v%0d_busy", v), 32'(bus.busy), 1);
            do_ticks(vecs[v].units - 1);
            chk($sformatf("v%0d_pre_done", v), 32'({bus.busy, bus.done}), 32'(2'b10));
            do_ticks(1);
            chk($sformatf("v%0d_done", v), 32'({bus.busy, bus.done}), 32'(2'b01));
            chk($sformatf("v%0d_fin_act", v), 32'(acts_now()), 0);
            cyc();
            chk($sformatf("v%0d_idle", v), 32'({bus.done, bus.phase}), 0);
        end

        // T1 phase order, loads and one decrement per unit.
        do_start(ProgT1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t1_phase%0d", k), 32'(bus.phase), 32'(k));
            chk($sformatf("t1_load%0d", k), 32'(bus.remain), 32'(loads[k]));
            chk($sformatf("t1_act%0d", k), 32'(acts_now()), 32'(pacts[k]));
            do_ticks(1);
            if (k < 7 || loads[k] > 1)
                chk($sformatf("t1_dec%0d", k), 32'(bus.remain), 32'(loads[k] - 1));
            do_ticks(loads[k] - 1);
        end
        chk("t1_done", 32'(bus.done), 1);
        cyc();
        chk("t1_busy_fall", 32'({bus.busy, bus.done}), 0);

        // T3 zero program.
        do_start(26'd0);
        chk("t3_done", 32'({bus.busy, bus.done}), 32'(2'b01));
        cyc();
        chk("t3_after", 32'({bus.busy, bus.done}), 0);

        // T4 pause in phase 1; tick in the pause-entry cycle is dropped.
        do_start(26'd7 << 19);
        bus.pause = 1'b1;
        bus.tick  = 1'b1;
        cyc();
        bus.tick  = 1'b0;
        chk("t4_pause_busy", 32'(bus.busy), 1);
        chk("t4_pause_remain", 32'(bus.remain), 7);
        chk("t4_pause_act", 32'(acts_now()), 0);
        do_ticks(5);
        chk("t4_hold_remain", 32'(bus.remain), 7);
        chk("t4_hold_wash", 32'(bus.motor_wash), 0);
        bus.pause = 1'b0;
        cyc();
        chk("t4_resume", 32'({bus.motor_wash, bus.phase, bus.remain}), 32'({1'b1, 3'd1, 4'd7}));
        do_ticks(6);
        chk("t4_not_done", 32'(bus.done), 0);
        do_ticks(1);
        chk("t4_done", 32'(bus.done), 1);
        cyc();

        // T5 abort with start during phase 5.
        do_start(ProgT1);
        do_ticks(25);
        chk("t5_in_ph5", 32'({bus.phase, bus.remain}), 32'({3'd5, 4'd8}));
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.prog  = 26'd7 << 19;
        cyc();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("t5_idle", 32'({bus.busy, bus.done, bus.phase, bus.remain}), 0);
        chk("t5_act", 32'(acts_now()), 0);
        cyc();
        chk("t5_no_done", 32'({bus.busy, bus.done}), 0);

        // Start held with pause high: RUN, then PAUSE.
        bus.pause = 1'b1;
        do_start(26'd1);
        chk("sp_run", 32'({bus.busy, bus.motor_spin}), 32'(2'b11));
        cyc();
        chk("sp_pause", 32'({bus.busy, bus.motor_spin}), 32'(2'b10));
        bus.pause = 1'b0;
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;

        // Asynchronous reset mid-run.
        do_start(ProgT1);
        do_ticks(5);
        rst_n = 1'b0;
        #1;
        chk("mrst_state", 32'({bus.busy, bus.done, bus.phase, bus.remain}), 0);
        chk("mrst_act", 32'(acts_now()), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("mrst_no_done", 32'(bus.done), 0);

`ifdef LID_LOCK_EN
        // T6 lid interlock.
        do_start(ProgT1);
        bus.lid_open = 1'b1;
        cyc();
        bus.lid_open = 1'b0;
        chk("t6_err", 32'({bus.err, bus.busy}), 32'(2'b11));
        chk("t6_act", 32'(acts_now()), 0);
        bus.pause = 1'b1;
        cyc();
        bus.pause = 1'b0;
        do_ticks(3);
        chk("t6_stuck", 32'({bus.err, bus.remain, acts_now()}), 32'({1'b1, 4'd3, 4'd0}));
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        chk("t6_clear", 32'({bus.err, bus.busy}), 0);
        do_start(ProgT1);
        chk("t6_rerun", 32'({bus.phase, bus.remain, acts_now()}), 32'({3'd0, 4'd3, 4'b1000}));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
